// File: rtl/spi_frame_pkg.sv
// Shared frame geometry, FSM state type and header construction for the SPI frame master.
package spi_frame_pkg;

    localparam int unsigned FRAME_BITS     = 40;
    localparam int unsigned HDR_BITS       = 8;
    localparam int unsigned PAYLOAD_BITS   = 32;
    localparam int unsigned WRITE_FLAG_POS = 7;
    localparam int unsigned ADDR_BITS      = 4;
    localparam int unsigned TIMER_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } state_t;

    // Header byte: write flag in the MSB, three zero bits, register index in the low nibble.
    function automatic logic [HDR_BITS-1:0] build_header(
        input logic                 write,
        input logic [ADDR_BITS-1:0] addr
    );
        logic [HDR_BITS-1:0] hdr;
        hdr                 = '0;
        hdr[WRITE_FLAG_POS] = write;
        hdr[ADDR_BITS-1:0]  = addr;
        return hdr;
    endfunction

endpackage

// File: rtl/spi_half_timer.sv
// Reloadable down-counter timing SPI clock half-periods and the chip-select gap.
module spi_half_timer
    import spi_frame_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               tc
);

    logic [TIMER_W-1:0] cnt;

    // A load of N yields tc in the N-th cycle after the load edge, so a phase lasts exactly N cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == TIMER_W'(1));

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 master sending 40-bit frames (8-bit header + 32-bit payload) and capturing MISO payload.
module spi_frame_master
    import spi_frame_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_BITS-1:0]    req_addr,
    input  logic [PAYLOAD_BITS-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [PAYLOAD_BITS-1:0] rsp_rdata,
    output logic                    SPI_CLK,
    output logic                    SPI_CS,
    output logic                    SPI_MOSI,
    input  logic                    SPI_MISO
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS);
    localparam logic [5:0] HDR_LAST = 6'(HDR_BITS);

    state_t                  state;
    logic [FRAME_BITS-1:0]   tx_shift;
    logic [FRAME_BITS-1:0]   frame_word;
    logic [PAYLOAD_BITS-1:0] rx_shift;
    logic [5:0]              bit_cnt;
    logic                    gap_first;
    logic                    miso_meta;
    logic                    miso_sync;
    logic                    accept;
    logic                    timer_load;
    logic                    timer_tc;
    logic [TIMER_W-1:0]      timer_val;

    assign accept = req_valid & req_ready;

    // Assemble the outgoing frame from the live request fields; only used on the accepting edge.
    always_comb begin
        frame_word = {build_header(req_write, req_addr), (req_write ? req_wdata : '0)};
    end

    // Reload the half-period timer at each phase boundary; the last LOW phase loads the CS gap instead.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = TIMER_W'(CLK_DIV);
        case (state)
            ST_IDLE:           timer_load = accept;
            ST_SETUP, ST_HIGH: timer_load = timer_tc;
            ST_LOW: begin
                timer_load = timer_tc;
                if (bit_cnt == LAST_BIT) begin
                    timer_val = TIMER_W'(CS_GAP);
                end
            end
            default:           timer_load = 1'b0;
        endcase
    end

    spi_half_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc)
    );

    // Two-flop resynchroniser for the asynchronous MISO line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= SPI_MISO;
            miso_sync <= miso_meta;
        end
    end

    // Frame sequencer: drives the bus, shifts MOSI out and MISO in, and reports completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            SPI_CLK   <= 1'b0;
            SPI_CS    <= 1'b1;
            SPI_MOSI  <= 1'b0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            gap_first <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SETUP;
                        req_ready <= 1'b0;
                        SPI_CS    <= 1'b0;
                        tx_shift  <= frame_word;
                        SPI_MOSI  <= frame_word[FRAME_BITS-1];
                        bit_cnt   <= '0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (timer_tc) begin
                        state   <= ST_HIGH;
                        SPI_CLK <= 1'b1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (timer_tc) begin
                        if (bit_cnt > HDR_LAST) begin
                            rx_shift <= {rx_shift[PAYLOAD_BITS-2:0], miso_sync};
                        end
                        state   <= ST_LOW;
                        SPI_CLK <= 1'b0;
                        if (bit_cnt < LAST_BIT) begin
                            SPI_MOSI <= tx_shift[FRAME_BITS-2];
                            tx_shift <= tx_shift << 1;
                        end else begin
                            SPI_MOSI <= 1'b0;
                        end
                    end
                end
                ST_LOW: begin
                    if (timer_tc) begin
                        if (bit_cnt == LAST_BIT) begin
                            state     <= ST_GAP;
                            SPI_CS    <= 1'b1;
                            SPI_MOSI  <= 1'b0;
                            gap_first <= 1'b1;
                        end else begin
                            state   <= ST_HIGH;
                            SPI_CLK <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    // The response is registered off the first GAP cycle, so it appears one edge after CS rises.
                    if (gap_first) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rx_shift;
                        gap_first <= 1'b0;
                    end
                    if (timer_tc) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
